demorgan_sweep_ctrl: RTL and testbench

//  Self-test sequencer for the two-input De Morgan gate unit (A,B -> ~A,~B,~A~B,~A+~B,~(AB),~(A+B)).
//  On a start pulse it walks A,B through 00,01,10,11, waits for the unit to settle, then samples all
//  six outputs and checks them against golden values. It sits beside the gate unit as its

---
 rtl/demorgan_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_demorgan_sweep_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demorgan_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : demorgan_sweep_ctrl
// Description: Self-test sequencer for a two-input De Morgan gate unit.
//              Walks {A,B} through 00,01,10,11 for LOOP_COUNT sweeps, waits
//              SETTLE_CYCLES per combination, samples the six gate outputs,
//              checks them against golden values and reports pass/fail, a
//              sticky per-combination error map and a saturating fail count.
// Revision   : 1.0 - initial release
// ============================================================================
module demorgan_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1,   // legal range 1..15
  parameter int LOOP_COUNT    = 1    // legal range 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       nA_in,
  input  logic       nB_in,
  input  logic       nAandnB_in,
  input  logic       nAornB_in,
  input  logic       AnandB_in,
  input  logic       AnorB_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_vec,
  output logic [7:0] fail_count
);

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] c_LAST_LOOP   = 8'(LOOP_COUNT - 1);
  localparam logic [7:0] c_FAIL_SAT    = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     r_state;
  logic [1:0] r_idx;
  logic [7:0] r_loop;
  logic [3:0] r_settle;

  logic [5:0] w_golden;
  logic [5:0] w_observed;
  logic       w_mismatch;
  logic [7:0] w_fail_next;

  // Golden gate outputs derived from the registered drives, in port order.
  always_comb begin
    w_golden    = {~a_out, ~b_out, ~a_out & ~b_out, ~a_out | ~b_out,
                   ~(a_out & b_out), ~(a_out | b_out)};
    w_observed  = {nA_in, nB_in, nAandnB_in, nAornB_in, AnandB_in, AnorB_in};
    w_mismatch  = |(w_golden ^ w_observed);
    w_fail_next = fail_count;
    if (w_mismatch && (fail_count != c_FAIL_SAT)) begin
      w_fail_next = fail_count + 8'd1;
    end
  end

  // Sequencer: drive, settle, check each combination, then report in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_loop     <= 8'd0;
      r_settle   <= 4'd0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_vec    <= 4'd0;
      fail_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_DRIVE;
            r_idx      <= 2'd0;
            r_loop     <= 8'd0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_vec    <= 4'd0;
            fail_count <= 8'd0;
          end
        end
        S_DRIVE: begin
          {a_out, b_out} <= r_idx;
          r_settle       <= c_SETTLE_LOAD;
          r_state        <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == 4'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        S_CHECK: begin
          fail_count <= w_fail_next;
          if (w_mismatch) begin
            err_vec[r_idx] <= 1'b1;
          end
          if ((r_idx == 2'd3) && (r_loop == c_LAST_LOOP)) begin
            // Final check folds straight into pass so DONE already shows it.
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_fail_next == 8'd0);
          end else if (r_idx == 2'd3) begin
            r_idx   <= 2'd0;
            r_loop  <= r_loop + 8'd1;
            r_state <= S_DRIVE;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_state <= S_DRIVE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demorgan_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_demorgan_sweep_ctrl
// Description: Self-checking bench for demorgan_sweep_ctrl. Three instances
//              (LOOP 1/3/255) each face a gate-unit model with a selectable
//              fault; expected run results are queued when a run is started
//              and compared when the instance pulses done.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_demorgan_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start_v;
  logic [1:0] fault_m [3];

  wire  [2:0] a_v, b_v, busy_v, done_v, pass_v;
  wire  [3:0] err_v [3];
  wire  [7:0] fc_v  [3];

  int n_checks = 0;
  int n_errors = 0;

  // expected record: {pass, err_vec[3:0], fail_count[7:0]}
  logic [12:0] q0[$];
  logic [12:0] q1[$];
  logic [12:0] q2[$];

  always #5 clk = ~clk;

  // Gate unit model: 0 healthy, 1 AnandB stuck 0, 2 nA stuck 1, 3 all inverted.
  function automatic logic [5:0] gate_model(input logic a, input logic b, input logic [1:0] f);
    logic [5:0] g;
    g = {~a, ~b, ~a & ~b, ~a | ~b, ~(a & b), ~(a | b)};
    case (f)
      2'd1:    g[1] = 1'b0;
      2'd2:    g[5] = 1'b1;
      2'd3:    g    = ~g;
      default: g    = g;
    endcase
    return g;
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int c_LOOP   = (gi == 0) ? 1 : (gi == 1) ? 3 : 255;
      localparam int c_SETTLE = (gi == 1) ? 2 : 1;
      wire [5:0] w_gu = gate_model(a_v[gi], b_v[gi], fault_m[gi]);
      demorgan_sweep_ctrl #(
        .SETTLE_CYCLES(c_SETTLE),
        .LOOP_COUNT   (c_LOOP)
      ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start_v[gi]),
        .a_out      (a_v[gi]),
        .b_out      (b_v[gi]),
        .nA_in      (w_gu[5]),
        .nB_in      (w_gu[4]),
        .nAandnB_in (w_gu[3]),
        .nAornB_in  (w_gu[2]),
        .AnandB_in  (w_gu[1]),
        .AnorB_in   (w_gu[0]),
        .busy       (busy_v[gi]),
        .done       (done_v[gi]),
        .pass       (pass_v[gi]),
        .err_vec    (err_v[gi]),
        .fail_count (fc_v[gi])
      );
    end
  endgenerate

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic p, input logic [3:0] e, input logic [7:0] fc);
    case (i)
      0:       q0.push_back({p, e, fc});
      1:       q1.push_back({p, e, fc});
      default: q2.push_back({p, e, fc});
    endcase
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start_v[i] = 1'b1;
    @(posedge clk); #1 start_v[i] = 1'b0;
  endtask

  // Waits (bounded) for done on instance i, counting busy cycles on the way.
  task automatic wait_done(input int i, input int max_cyc, output int busy_cyc);
    busy_cyc = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (done_v[i] === 1'b1) break;
      if (busy_v[i] === 1'b1) busy_cyc++;
    end
    check_val($sformatf("d%0d_done_seen", i), {31'd0, done_v[i]}, 32'd1);
    check_val($sformatf("d%0d_busy_low_at_done", i), {31'd0, busy_v[i]}, 32'd0);
  endtask

  task automatic check_idle_zero(input int i, input string tag);
    check_val({tag, "_ab"},   {30'd0, a_v[i], b_v[i]}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy_v[i]}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done_v[i]}, 32'd0);
    check_val({tag, "_pass"}, {31'd0, pass_v[i]}, 32'd0);
    check_val({tag, "_err"},  {28'd0, err_v[i]}, 32'd0);
    check_val({tag, "_fc"},   {24'd0, fc_v[i]}, 32'd0);
  endtask

  // Scoreboard: every done pops one queued expectation.
  always @(negedge clk) begin : p_mon
    logic [12:0] e;
    bit          have;
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) begin
        have = 1'b0;
        e    = '0;
        case (i)
          0:       if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
          1:       if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          check_val($sformatf("d%0d_unexpected_done", i), {31'd0, done_v[i]}, 32'd0);
        end else begin
          check_val($sformatf("d%0d_pass", i), {31'd0, pass_v[i]}, {31'd0, e[12]});
          check_val($sformatf("d%0d_err_vec", i), {28'd0, err_v[i]}, {28'd0, e[11:8]});
          check_val($sformatf("d%0d_fail_count", i), {24'd0, fc_v[i]}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin
    int  bc;
    bit  seen;
    reset   = 1'b1;
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) fault_m[i] = 2'd0;

    // Reset state on all instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle_zero(i, $sformatf("d%0d_reset", i));
    @(posedge clk); #1 reset = 1'b0;

    // 1: healthy unit, SETTLE=1, LOOP=1
    push_exp(0, 1'b1, 4'b0000, 8'd0);
    pulse_start(0);
    wait_done(0, 100, bc);
    check_val("t1_busy_cycles", bc, 32'd12);
    @(negedge clk);
    check_val("t1_done_one_cycle", {31'd0, done_v[0]}, 32'd0);
    check_val("t1_ab_hold", {30'd0, a_v[0], b_v[0]}, 32'd3);

    // 2: AnandB stuck at 0
    fault_m[0] = 2'd1;
    push_exp(0, 1'b0, 4'b0111, 8'd3);
    pulse_start(0);
    wait_done(0, 100, bc);
    repeat (5) @(negedge clk);
    check_val("t2_err_hold", {28'd0, err_v[0]}, 32'h7);
    check_val("t2_fc_hold", {24'd0, fc_v[0]}, 32'd3);
    check_val("t2_pass_hold", {31'd0, pass_v[0]}, 32'd0);
    check_val("t2_ab_hold", {30'd0, a_v[0], b_v[0]}, 32'd3);

    // 3: nA stuck at 1, LOOP=3, SETTLE=2
    fault_m[1] = 2'd2;
    push_exp(1, 1'b0, 4'b1100, 8'd6);
    pulse_start(1);
    wait_done(1, 200, bc);
    check_val("t3_busy_cycles", bc, 32'd48);

    // 4: reset during SETTLE of combination 2, no done for the aborted run
    fault_m[0] = 2'd1;
    pulse_start(0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_v[0] === 1'b1 && b_v[0] === 1'b0) begin seen = 1'b1; break; end
    end
    check_val("t4_reached_combo2", {31'd0, seen}, 32'd1);
    check_val("t4_busy_before_reset", {31'd0, busy_v[0]}, 32'd1);
    reset = 1'b1;
    #1;
    check_idle_zero(0, "t4_async_reset");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    fault_m[0] = 2'd0;
    push_exp(0, 1'b1, 4'b0000, 8'd0);
    pulse_start(0);
    wait_done(0, 100, bc);
    check_val("t4_clean_busy_cycles", bc, 32'd12);

    // 5: start held high across a run, extra pulses while busy
    push_exp(0, 1'b1, 4'b0000, 8'd0);
    push_exp(0, 1'b1, 4'b0000, 8'd0);
    @(posedge clk); #1 start_v[0] = 1'b1;
    wait_done(0, 100, bc);
    check_val("t5_run1_busy_cycles", bc, 32'd12);
    @(negedge clk);
    check_val("t5_idle_busy", {31'd0, busy_v[0]}, 32'd0);
    @(negedge clk);
    check_val("t5_rerun_busy", {31'd0, busy_v[0]}, 32'd1);
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      @(posedge clk);
    end
    wait_done(0, 50, bc);
    start_v[0] = 1'b1;                       // pulse inside the DONE cycle
    @(posedge clk); #1 start_v[0] = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy_v[0] !== 1'b0) seen = 1'b1;
    end
    check_val("t5_no_extra_run", {31'd0, seen}, 32'd0);

    // 6: all outputs inverted, LOOP=255 -> fail_count saturates
    fault_m[2] = 2'd3;
    push_exp(2, 1'b0, 4'b1111, 8'd255);
    pulse_start(2);
    wait_done(2, 4000, bc);
    check_val("t6_busy_cycles", bc, 32'd3060);

    repeat (3) @(negedge clk);
    check_val("sb_pending", q0.size() + q1.size() + q2.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
